// File: rtl/sub_a_b_c2_pipe_pkg.sv
// ---------------------------------------------------------------
// sub_a_b_c2_pipe_pkg : constants shared by the a-b-c2 subtractor
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package sub_a_b_c2_pipe_pkg;
  localparam int c_BORROW_W = 2;
endpackage

`default_nettype wire

// File: rtl/sub_c2_seg.sv
// ---------------------------------------------------------------
// sub_c2_seg : one segment of a - b - bin with a 2-bit borrow out
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sub_c2_seg
  import sub_a_b_c2_pipe_pkg::*;
#(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0]        a_seg,
  input  logic [SEG-1:0]        b_seg,
  input  logic [c_BORROW_W-1:0] bin,
  output logic [SEG-1:0]        diff,
  output logic [c_BORROW_W-1:0] bout
);

  logic [SEG+1:0] w_d;

  assign w_d  = {2'b00, a_seg} - {2'b00, b_seg} - {{SEG{1'b0}}, bin};
  assign diff = w_d[SEG-1:0];
  // Sign bit set means negative; bit SEG then separates [-2^SEG, 0) from below -2^SEG.
  assign bout = w_d[SEG+1] ? (w_d[SEG] ? 2'd1 : 2'd2) : 2'd0;

endmodule

`default_nettype wire

// File: rtl/sub_a_b_c2_pipe.sv
// ---------------------------------------------------------------
// sub_a_b_c2_pipe : pipelined (a - b - c2), one stage per SEG bits
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sub_a_b_c2_pipe
  import sub_a_b_c2_pipe_pkg::*;
#(
  parameter int SIZE = 64,
  parameter int SEG  = 16
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE-1:0]       a,
  input  logic [SIZE-1:0]       b,
  input  logic [1:0]            c2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE-1:0]       out,
  output logic [c_BORROW_W-1:0] borrow_out
);

  localparam int STAGES = SIZE / SEG;

  if ((SEG < 2) || (SIZE % SEG != 0)) begin : g_param_check
    $error("sub_a_b_c2_pipe: SIZE must be a multiple of SEG and SEG must be >= 2");
  end

  logic [STAGES-1:0]            r_v;
  logic                         w_advance;
  logic [STAGES*c_BORROW_W-1:0] w_bout_q;

  // Single global stall: every stage moves together, bubbles are kept.
  assign w_advance  = !r_v[STAGES-1] || out_ready;
  assign in_ready   = w_advance;
  assign out_valid  = r_v[STAGES-1];
  assign borrow_out = w_bout_q[(STAGES-1)*c_BORROW_W +: c_BORROW_W];

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_v <= '0;
    end else if (w_advance) begin
      r_v[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        r_v[i] <= r_v[i-1];
      end
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_seg
    logic [SEG-1:0]        w_a;
    logic [SEG-1:0]        w_b;
    logic [SEG-1:0]        w_diff;
    logic [c_BORROW_W-1:0] w_bin;
    logic [c_BORROW_W-1:0] w_bout;
    logic [c_BORROW_W-1:0] r_bout;
    logic [SEG-1:0]        r_res [STAGES-j];

    if (j == 0) begin : g_first
      assign w_a   = a[SEG-1:0];
      assign w_b   = b[SEG-1:0];
      assign w_bin = c2;
    end else begin : g_skew
      // Segment j waits j cycles so it meets the borrow rippling up from below.
      logic [SEG-1:0] r_a_dly [j];
      logic [SEG-1:0] r_b_dly [j];

      always_ff @(posedge clk) begin
        if (sclr) begin
          for (int i = 0; i < j; i++) begin
            r_a_dly[i] <= '0;
            r_b_dly[i] <= '0;
          end
        end else if (w_advance) begin
          r_a_dly[0] <= a[j*SEG +: SEG];
          r_b_dly[0] <= b[j*SEG +: SEG];
          for (int i = 1; i < j; i++) begin
            r_a_dly[i] <= r_a_dly[i-1];
            r_b_dly[i] <= r_b_dly[i-1];
          end
        end
      end

      assign w_a   = r_a_dly[j-1];
      assign w_b   = r_b_dly[j-1];
      assign w_bin = w_bout_q[(j-1)*c_BORROW_W +: c_BORROW_W];
    end

    sub_c2_seg #(
      .SEG (SEG)
    ) u_seg (
      .a_seg (w_a),
      .b_seg (w_b),
      .bin   (w_bin),
      .diff  (w_diff),
      .bout  (w_bout)
    );

    always_ff @(posedge clk) begin
      if (sclr) begin
        r_bout <= '0;
        for (int i = 0; i < STAGES - j; i++) begin
          r_res[i] <= '0;
        end
      end else if (w_advance) begin
        r_bout   <= w_bout;
        r_res[0] <= w_diff;
        for (int i = 1; i < STAGES - j; i++) begin
          r_res[i] <= r_res[i-1];
        end
      end
    end

    assign w_bout_q[j*c_BORROW_W +: c_BORROW_W] = r_bout;
    assign out[j*SEG +: SEG]                    = r_res[STAGES-1-j];
  end

endmodule

`default_nettype wire

// File: tb/tb_sub_a_b_c2_pipe.sv
// ---------------------------------------------------------------
// tb_sub_a_b_c2_pipe : bench for sub_a_b_c2_pipe against a whole-word model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_sub_a_b_c2_pipe;

  localparam int SIZE   = 64;
  localparam int SEG    = 16;
  localparam int STAGES = SIZE / SEG;

  logic            clk = 1'b0;
  logic            sclr;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic [1:0]      c2;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out;
  logic [1:0]      borrow_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sub_a_b_c2_pipe #(
    .SIZE (SIZE),
    .SEG  (SEG)
  ) dut (
    .clk        (clk),
    .sclr       (sclr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .c2         (c2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .borrow_out (borrow_out)
  );

  // Whole-word reference: true difference, then split into low word and borrow count.
  function automatic void ref_model(input logic [SIZE-1:0] ra, input logic [SIZE-1:0] rb,
                                    input logic [1:0] rc, output logic [SIZE-1:0] ro,
                                    output logic [1:0] rbo);
    logic signed [SIZE+2:0] d;
    logic signed [SIZE+2:0] lim;
    d = $signed({3'b000, ra}) - $signed({3'b000, rb}) - $signed({{(SIZE+1){1'b0}}, rc});
    lim = '0;
    lim[SIZE] = 1'b1;
    lim = -lim;
    ro = d[SIZE-1:0];
    if (d >= 0)        rbo = 2'd0;
    else if (d >= lim) rbo = 2'd1;
    else               rbo = 2'd2;
  endfunction

  function automatic logic [SIZE-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sclr = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; a = 64'd7; b = 64'd1; c2 = 2'd0;
    step();
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL reset_out got=%h want=0", out); end
    n_cmp++; if (borrow_out !== 2'd0) begin n_bad++; $display("FAIL reset_borrow got=%0d want=0", borrow_out); end
    step();
    sclr = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle_valid cyc=%0d got=%b want=0", i, out_valid); end
      step();
    end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 64'd100; b = 64'd58; c2 = 2'd3;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lat_in_ready got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (out_valid !== (i == STAGES - 1)) begin
        n_bad++; $display("FAIL lat_valid edge=%0d got=%b want=%b", i, out_valid, (i == STAGES - 1));
      end
      if (i == STAGES - 1) begin
        n_cmp++; if (out !== 64'd39) begin n_bad++; $display("FAIL lat_out got=%0d want=39", out); end
        n_cmp++; if (borrow_out !== 2'd0) begin n_bad++; $display("FAIL lat_borrow got=%0d want=0", borrow_out); end
      end
      step();
    end
  endtask

  task automatic test_vectors();
    logic [SIZE-1:0] ta [9];
    logic [SIZE-1:0] tb [9];
    logic [1:0]      tc [9];
    logic [SIZE-1:0] eo;
    logic [1:0]      eb;
    int              waited;
    ta[0] = '0;                    tb[0] = '1;     tc[0] = 2'd3;
    ta[1] = 64'h0001_0000_0000_0000; tb[1] = '0;   tc[1] = 2'd1;
    ta[2] = rand_word();           tb[2] = ta[2];  tc[2] = 2'd0;
    ta[3] = '0;                    tb[3] = '0;     tc[3] = 2'd1;
    ta[4] = '0;                    tb[4] = '1;     tc[4] = 2'd2;
    for (int i = 5; i < 9; i++) begin
      ta[i] = rand_word(); tb[i] = rand_word(); tc[i] = 2'($urandom_range(0, 3));
    end
    out_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      ref_model(ta[v], tb[v], tc[v], eo, eb);
      in_valid = 1'b1; a = ta[v]; b = tb[v]; c2 = tc[v];
      step();
      in_valid = 1'b0;
      waited = 0;
      #1;
      while (!out_valid && waited < 12) begin
        step(); #1; waited++;
      end
      n_cmp++; if (waited !== STAGES - 1) begin n_bad++; $display("FAIL vec%0d_latency got=%0d want=%0d", v, waited, STAGES - 1); end
      n_cmp++; if (out !== eo) begin n_bad++; $display("FAIL vec%0d_out got=%h want=%h", v, out, eo); end
      n_cmp++; if (borrow_out !== eb) begin n_bad++; $display("FAIL vec%0d_borrow got=%0d want=%0d", v, borrow_out, eb); end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [SIZE-1:0] va [8];
    logic [SIZE-1:0] vb [8];
    logic [1:0]      vc [8];
    logic [SIZE-1:0] exp_o [$];
    logic [1:0]      exp_b [$];
    logic [SIZE-1:0] eo;
    logic [1:0]      eb;
    logic [SIZE-1:0] prev_out;
    logic [1:0]      prev_bo;
    logic            prev_stall;
    int              idx;
    int              popped;
    int              cyc;
    for (int i = 0; i < 8; i++) begin
      va[i] = rand_word(); vb[i] = rand_word(); vc[i] = 2'($urandom_range(0, 3));
    end
    idx = 0; popped = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0; prev_bo = '0;
    while (popped < 8 && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc <= 9);
      in_valid  = (idx < 8);
      if (idx < 8) begin a = va[idx]; b = vb[idx]; c2 = vc[idx]; end
      #1;
      if (prev_stall) begin
        n_cmp++; if (out !== prev_out) begin n_bad++; $display("FAIL bp_hold_out cyc=%0d got=%h want=%h", cyc, out, prev_out); end
        n_cmp++; if (borrow_out !== prev_bo) begin n_bad++; $display("FAIL bp_hold_borrow cyc=%0d got=%0d want=%0d", cyc, borrow_out, prev_bo); end
      end
      if (out_valid && !out_ready) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_stall cyc=%0d got=%b want=0", cyc, in_ready); end
      end
      if (out_valid && out_ready) begin
        if (exp_o.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL bp_extra_output cyc=%0d got=%h want=none", cyc, out);
        end else begin
          eo = exp_o.pop_front(); eb = exp_b.pop_front();
          n_cmp++; if (out !== eo) begin n_bad++; $display("FAIL bp_out item=%0d got=%h want=%h", popped, out, eo); end
          n_cmp++; if (borrow_out !== eb) begin n_bad++; $display("FAIL bp_borrow item=%0d got=%0d want=%0d", popped, borrow_out, eb); end
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        ref_model(va[idx], vb[idx], vc[idx], eo, eb);
        exp_o.push_back(eo); exp_b.push_back(eb);
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = out; prev_bo = borrow_out;
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (popped !== 8) begin n_bad++; $display("FAIL bp_count got=%0d want=8", popped); end
    n_cmp++; if (exp_o.size() !== 0) begin n_bad++; $display("FAIL bp_leftover got=%0d want=0", exp_o.size()); end
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_duplicate cyc=%0d got=%b want=0", i, out_valid); end
      step();
    end
  endtask

  task automatic test_midflight_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = rand_word(); b = rand_word(); c2 = 2'($urandom_range(0, 3));
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_push%0d_ready got=%b want=1", i, in_ready); end
      step();
    end
    sclr = 1'b1; in_valid = 1'b1; a = rand_word(); b = rand_word(); c2 = 2'd1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_pre_reset_valid got=%b want=0", out_valid); end
    step();
    sclr = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_flushed cyc=%0d got=%b want=0", i, out_valid); end
      step();
    end
    in_valid = 1'b1; a = 64'd5; b = 64'd2; c2 = 2'd0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (out_valid !== (i == STAGES - 1)) begin
        n_bad++; $display("FAIL mid_after_valid edge=%0d got=%b want=%b", i, out_valid, (i == STAGES - 1));
      end
      if (i == STAGES - 1) begin
        n_cmp++; if (out !== 64'd3) begin n_bad++; $display("FAIL mid_after_out got=%0d want=3", out); end
        n_cmp++; if (borrow_out !== 2'd0) begin n_bad++; $display("FAIL mid_after_borrow got=%0d want=0", borrow_out); end
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    sclr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c2 = 2'd0;
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_midflight_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sub_a_b_c2_pipe.md
Name: sub_a_b_c2_pipe

Overview:
- Pipelined wide subtractor; inverse operation of the team's a+b+c2 adder.
- Computes a - b - c2, where c2 is a 2-bit borrow-in worth 0..3.
- Operands are split into SEG-bit segments, one pipeline stage per segment, with the borrow rippled stage to stage.
- Sits in arithmetic datapaths needing wide subtraction at high Fmax; valid/ready on both sides with full backpressure.

Parameters:
- SIZE, 64, operand and result width; must be a multiple of SEG.
- SEG, 16, segment width per pipeline stage; must be >= 2. Elaboration error otherwise.

Ports:
- clk  input  1  clock.
- sclr  input  1  synchronous active-high reset.
- in_valid  input  1  a/b/c2 valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- a  input  SIZE  minuend.
- b  input  SIZE  subtrahend.
- c2  input  2  borrow-in, unsigned 0..3.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out  output  SIZE  (a - b - c2) mod 2^SIZE.
- borrow_out  output  2  final borrow, 0..2. The true result is out - borrow_out*2^SIZE.

Behaviour:
- Clock, reset and interface basics:
  - One clock; reset is synchronous and active-high: clk and sclr.
  - STAGES = SIZE/SEG.
  - Transfer in: in_valid && in_ready at a clk edge.
  - Transfer out: out_valid && out_ready at a clk edge.
- Pipeline:
  - Per-stage valid bits v[0..STAGES-1]. out_valid = v[STAGES-1].
  - Global stall: advance = !out_valid || out_ready. in_ready = advance.
  - in_ready is combinational from out_valid/out_ready only, never from in_valid.
  - On advance, every stage loads from its predecessor. v[0] loads in_valid.
  - On !advance, all stage registers and valids hold. Bubbles are not squeezed.
  - Latency: result for an input accepted at edge N is presented (out_valid=1) after edge N+STAGES-1, i.e. STAGES cycles, provided no stall. Throughput is 1 per cycle.
- Stage k arithmetic (k = 0..STAGES-1):
  - d = a[k] - b[k] - bin_k, computed in SEG+2 bits.
  - Segment result is d mod 2^SEG.
  - bout_k = 0 if d >= 0; 1 if -2^SEG <= d < 0; 2 if d < -2^SEG.
  - bin_0 = c2; bin_k = bout_{k-1}, registered.
  - The 2-bit borrow is required: a=0, b=all ones, bin=3 gives borrow 2. bin = 2 with the worst operands also yields 2; the borrow never exceeds 2.
- Skew and deskew:
  - Input segments k >= 1 are delayed k stages: a triangular skew register carries unconsumed segments forward.
  - Computed result segments are delayed STAGES-1-k stages so all of out aligns with v[STAGES-1].
  - borrow_out = bout_{STAGES-1}.
- Reset:
  - All v[] = 0, out_valid = 0, out = 0, borrow_out = 0, internal borrows = 0.
  - in_ready = 1 while out_valid = 0, including the reset cycle itself.
  - sclr mid-operation discards all in-flight items. No partial output is ever shown.
  - An input presented with in_valid while sclr = 1 is dropped.
- Boundaries:
  - out and borrow_out hold stable while out_valid && !out_ready.
  - Simultaneous output pop and input push in a full pipe: both occur; occupancy stays the same.
  - c2 = 0 with a = b gives out = 0, borrow_out = 0.
  - Data registers may hold stale values when the matching v = 0; only valid-qualified values are checked.

Decomposition:
- No shared package typedefs are needed. localparam STAGES = SIZE/SEG lives in the module.
- A shared add_sub package holds the borrow width constant (2) if the adder family already has one.
- Sub-module sub_c2_seg (parameter SEG; combinational): inputs a_seg, b_seg, bin[1:0]; outputs diff[SEG-1:0], bout[1:0].
- The top instantiates STAGES copies and owns all registers, skew/deskew and handshake.

Test Plan (SIZE=64, SEG=16, latency 4):
- Reset/idle: sclr pulse, no input → out_valid=0, out=0, borrow_out=0, in_ready=1.
- Simple case: a=100, b=58, c2=3, out_ready=1 → 4 cycles later out=39, borrow_out=0, out_valid high for exactly 1 cycle.
- Max borrow: a=0, b=0xFFFF_FFFF_FFFF_FFFF, c2=3 → out=0xFFFF_FFFF_FFFF_FFFE, borrow_out=2.
- Segment ripple: a=0x0001_0000_0000_0000, b=0, c2=1 → out=0x0000_FFFF_FFFF_FFFF, borrow_out=0; the borrow crosses 3 segment boundaries.
- Backpressure: stream 8 random vectors back-to-back, out_ready=0 for cycles 5..9 → in_ready=0 during the stall, outputs hold, all 8 results emerge in order and match the reference model (a-b-c2, 66-bit), none lost or duplicated.
- Mid-flight reset: push 3 vectors, assert sclr one cycle after the 3rd is accepted → no out_valid for any of them; the next vector a=5, b=2, c2=0 yields out=3 after 4 cycles.
